ethernet_udp_header_parser: RTL and testbench

// - Byte-serial parser directly downstream of preamble/SFD detection in the Ethernet receive path.
// - Consumes the 42-byte Eth+IPv4+UDP header that follows the SFD: 6 dst MAC, 6 src MAC, 2 ethertype, 20 IPv4, 8 UDP.
// - Extracts the fields, checks them against fixed rules and presents them as registered outputs.
// - Emits a one-cycle valid or error verdict per frame.

---
 rtl/ethernet_udp_header_parser.sv | 207 ++++++++++++++++++++
 tb/tb_ethernet_udp_header_parser.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/ethernet_udp_header_parser.sv
// Byte-serial Eth+IPv4+UDP header parser. Verdict is a one-cycle pulse in DONE.
// Optional IPv4 header checksum verification is enabled by defining IP_CSUM_CHECK_EN.
module ethernet_udp_header_parser #(
    parameter logic [47:0] LOCAL_MAC  = 48'h02_00_00_00_00_01,
    parameter bit          MAC_FILTER = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic [7:0]  i_msg_word,
    input  logic        i_preambule_valid,
    output logic [47:0] o_dst_mac,
    output logic [47:0] o_src_mac,
    output logic [15:0] o_ethertype,
    output logic [31:0] o_src_ip,
    output logic [31:0] o_dst_ip,
    output logic [15:0] o_src_port,
    output logic [15:0] o_dst_port,
    output logic [15:0] o_udp_len,
    output logic        o_busy,
    output logic        o_hdr_valid,
    output logic        o_hdr_error,
    output logic [2:0]  o_fsm_state
);
    // Handshake: i_preambule_valid is a strobe with no ready; header bytes follow
    // on consecutive cycles, and o_hdr_valid/o_hdr_error are mutually exclusive strobes.
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ETH  = 3'd1,
        S_IP   = 3'd2,
        S_UDP  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic        err_q, err_d;
    logic [47:0] sh_dst_mac_q, sh_dst_mac_d, sh_src_mac_q, sh_src_mac_d;
    logic [15:0] sh_eth_q, sh_eth_d;
    logic [31:0] sh_src_ip_q, sh_src_ip_d, sh_dst_ip_q, sh_dst_ip_d;
    logic [15:0] sh_src_port_q, sh_src_port_d, sh_dst_port_q, sh_dst_port_d;
    logic [15:0] sh_udp_len_q, sh_udp_len_d;
    logic [47:0] dst_mac_q, dst_mac_d, src_mac_q, src_mac_d;
    logic [15:0] eth_q, eth_d;
    logic [31:0] src_ip_q, src_ip_d, dst_ip_q, dst_ip_d;
    logic [15:0] src_port_q, src_port_d, dst_port_q, dst_port_d;
    logic [15:0] udp_len_q, udp_len_d;
    logic [47:0] dst_next;
    logic        hdr_ok;
`ifdef IP_CSUM_CHECK_EN
    logic [19:0] csum_q, csum_d;
    logic [16:0] fold1;
    logic [15:0] fold2;
`endif

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        err_d         = err_q;
        sh_dst_mac_d  = sh_dst_mac_q;
        sh_src_mac_d  = sh_src_mac_q;
        sh_eth_d      = sh_eth_q;
        sh_src_ip_d   = sh_src_ip_q;
        sh_dst_ip_d   = sh_dst_ip_q;
        sh_src_port_d = sh_src_port_q;
        sh_dst_port_d = sh_dst_port_q;
        sh_udp_len_d  = sh_udp_len_q;
        dst_mac_d     = dst_mac_q;
        src_mac_d     = src_mac_q;
        eth_d         = eth_q;
        src_ip_d      = src_ip_q;
        dst_ip_d      = dst_ip_q;
        src_port_d    = src_port_q;
        dst_port_d    = dst_port_q;
        udp_len_d     = udp_len_q;
        dst_next      = {sh_dst_mac_q[39:0], i_msg_word};
        hdr_ok        = !err_q;
`ifdef IP_CSUM_CHECK_EN
        csum_d = csum_q;
        fold1  = {1'b0, csum_q[15:0]} + {13'd0, csum_q[19:16]};
        fold2  = fold1[15:0] + {15'd0, fold1[16]};
        hdr_ok = !err_q && (fold2 == 16'hFFFF);
`endif

        case (state_q)
            S_ETH, S_IP, S_UDP: begin
                cnt_d = cnt_q + 6'd1;
                if (cnt_q inside {[6'd0:6'd5]})   sh_dst_mac_d  = dst_next;
                if (cnt_q inside {[6'd6:6'd11]})  sh_src_mac_d  = {sh_src_mac_q[39:0], i_msg_word};
                if (cnt_q inside {[6'd12:6'd13]}) sh_eth_d      = {sh_eth_q[7:0], i_msg_word};
                if (cnt_q inside {[6'd26:6'd29]}) sh_src_ip_d   = {sh_src_ip_q[23:0], i_msg_word};
                if (cnt_q inside {[6'd30:6'd33]}) sh_dst_ip_d   = {sh_dst_ip_q[23:0], i_msg_word};
                if (cnt_q inside {[6'd34:6'd35]}) sh_src_port_d = {sh_src_port_q[7:0], i_msg_word};
                if (cnt_q inside {[6'd36:6'd37]}) sh_dst_port_d = {sh_dst_port_q[7:0], i_msg_word};
                if (cnt_q inside {[6'd38:6'd39]}) sh_udp_len_d  = {sh_udp_len_q[7:0], i_msg_word};
                // The MAC filter is judged once the whole destination address is in.
                if (cnt_q == 6'd5 && MAC_FILTER &&
                    dst_next != LOCAL_MAC && dst_next != 48'hFFFF_FFFF_FFFF) err_d = 1'b1;
                if (cnt_q == 6'd13 && {sh_eth_q[7:0], i_msg_word} != 16'h0800) err_d = 1'b1;
                if (cnt_q == 6'd14 && i_msg_word != 8'h45) err_d = 1'b1;
                if (cnt_q == 6'd23 && i_msg_word != 8'h11) err_d = 1'b1;
`ifdef IP_CSUM_CHECK_EN
                if (cnt_q inside {[6'd14:6'd33]})
                    csum_d = csum_q + (cnt_q[0] ? {12'd0, i_msg_word} : {4'd0, i_msg_word, 8'd0});
`endif
                if (state_q == S_ETH && cnt_q == 6'd13) state_d = S_IP;
                if (state_q == S_IP  && cnt_q == 6'd33) state_d = S_UDP;
                if (state_q == S_UDP && cnt_q == 6'd41) state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
                cnt_d   = 6'd0;
                if (hdr_ok) begin
                    dst_mac_d  = sh_dst_mac_q;
                    src_mac_d  = sh_src_mac_q;
                    eth_d      = sh_eth_q;
                    src_ip_d   = sh_src_ip_q;
                    dst_ip_d   = sh_dst_ip_q;
                    src_port_d = sh_src_port_q;
                    dst_port_d = sh_dst_port_q;
                    udp_len_d  = sh_udp_len_q;
                end
            end
            default: ;
        endcase

        // A new preamble always wins over an in-flight header; output loading in DONE is kept.
        if (i_preambule_valid) begin
            state_d       = S_ETH;
            cnt_d         = 6'd0;
            err_d         = 1'b0;
            sh_dst_mac_d  = '0;
            sh_src_mac_d  = '0;
            sh_eth_d      = '0;
            sh_src_ip_d   = '0;
            sh_dst_ip_d   = '0;
            sh_src_port_d = '0;
            sh_dst_port_d = '0;
            sh_udp_len_d  = '0;
`ifdef IP_CSUM_CHECK_EN
            csum_d = '0;
`endif
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            err_q         <= 1'b0;
            sh_dst_mac_q  <= '0;
            sh_src_mac_q  <= '0;
            sh_eth_q      <= '0;
            sh_src_ip_q   <= '0;
            sh_dst_ip_q   <= '0;
            sh_src_port_q <= '0;
            sh_dst_port_q <= '0;
            sh_udp_len_q  <= '0;
            dst_mac_q     <= '0;
            src_mac_q     <= '0;
            eth_q         <= '0;
            src_ip_q      <= '0;
            dst_ip_q      <= '0;
            src_port_q    <= '0;
            dst_port_q    <= '0;
            udp_len_q     <= '0;
`ifdef IP_CSUM_CHECK_EN
            csum_q        <= '0;
`endif
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            err_q         <= err_d;
            sh_dst_mac_q  <= sh_dst_mac_d;
            sh_src_mac_q  <= sh_src_mac_d;
            sh_eth_q      <= sh_eth_d;
            sh_src_ip_q   <= sh_src_ip_d;
            sh_dst_ip_q   <= sh_dst_ip_d;
            sh_src_port_q <= sh_src_port_d;
            sh_dst_port_q <= sh_dst_port_d;
            sh_udp_len_q  <= sh_udp_len_d;
            dst_mac_q     <= dst_mac_d;
            src_mac_q     <= src_mac_d;
            eth_q         <= eth_d;
            src_ip_q      <= src_ip_d;
            dst_ip_q      <= dst_ip_d;
            src_port_q    <= src_port_d;
            dst_port_q    <= dst_port_d;
            udp_len_q     <= udp_len_d;
`ifdef IP_CSUM_CHECK_EN
            csum_q        <= csum_d;
`endif
        end
    end

    assign o_dst_mac   = dst_mac_q;
    assign o_src_mac   = src_mac_q;
    assign o_ethertype = eth_q;
    assign o_src_ip    = src_ip_q;
    assign o_dst_ip    = dst_ip_q;
    assign o_src_port  = src_port_q;
    assign o_dst_port  = dst_port_q;
    assign o_udp_len   = udp_len_q;
    assign o_busy      = (state_q == S_ETH) || (state_q == S_IP) || (state_q == S_UDP);
    assign o_hdr_valid = (state_q == S_DONE) && hdr_ok;
    assign o_hdr_error = (state_q == S_DONE) && !hdr_ok;
    assign o_fsm_state = state_q;
endmodule

// File: tb/tb_ethernet_udp_header_parser.sv
// Directed bench for ethernet_udp_header_parser: a filtering instance and a
// MAC_FILTER=0 instance share one byte stream.
module tb_ethernet_udp_header_parser;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pv = 1'b0;
    logic [7:0] msg = 8'h00;

    logic [47:0] m_dst_mac, m_src_mac, n_dst_mac, n_src_mac;
    logic [15:0] m_eth, m_sport, m_dport, m_ulen, n_eth, n_sport, n_dport, n_ulen;
    logic [31:0] m_sip, m_dip, n_sip, n_dip;
    logic        m_busy, m_valid, m_err, n_busy, n_valid, n_err;
    logic [2:0]  m_state, n_state;

    localparam logic [47:0] BCAST = 48'hFFFF_FFFF_FFFF;
    localparam logic [47:0] LMAC  = 48'h02_00_00_00_00_01;
    localparam logic [47:0] OTHER = 48'h02_00_00_00_00_02;
    localparam logic [47:0] SRC   = 48'h02_11_22_33_44_55;

    int checks = 0;
    int failures = 0;
    int vcnt = 0;
    int ecnt = 0;
    int both = 0;
    int v0, e0;
    logic [7:0] frm [42];

    always #5 clk = ~clk;

    ethernet_udp_header_parser dut (
        .i_clk(clk), .i_reset_n(rst_n), .i_msg_word(msg), .i_preambule_valid(pv),
        .o_dst_mac(m_dst_mac), .o_src_mac(m_src_mac), .o_ethertype(m_eth),
        .o_src_ip(m_sip), .o_dst_ip(m_dip), .o_src_port(m_sport), .o_dst_port(m_dport),
        .o_udp_len(m_ulen), .o_busy(m_busy), .o_hdr_valid(m_valid), .o_hdr_error(m_err),
        .o_fsm_state(m_state)
    );

    ethernet_udp_header_parser #(.MAC_FILTER(1'b0)) dut_nf (
        .i_clk(clk), .i_reset_n(rst_n), .i_msg_word(msg), .i_preambule_valid(pv),
        .o_dst_mac(n_dst_mac), .o_src_mac(n_src_mac), .o_ethertype(n_eth),
        .o_src_ip(n_sip), .o_dst_ip(n_dip), .o_src_port(n_sport), .o_dst_port(n_dport),
        .o_udp_len(n_ulen), .o_busy(n_busy), .o_hdr_valid(n_valid), .o_hdr_error(n_err),
        .o_fsm_state(n_state)
    );

    always @(negedge clk) begin
        if (m_valid) vcnt++;
        if (m_err) ecnt++;
        if (m_valid && m_err) both++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic build(input logic [47:0] dst, input logic [15:0] eth,
                         input logic [15:0] csum, input logic [15:0] sport);
        logic [159:0] iph;
        iph = {8'h45, 8'h00, 8'h00, 8'h73, 8'h00, 8'h00, 8'h40, 8'h00, 8'h40, 8'h11,
               csum, 32'hC0A8_0001, 32'hC0A8_00C7};
        for (int k = 0; k < 6; k++) frm[k] = dst[47-8*k -: 8];
        for (int k = 0; k < 6; k++) frm[6+k] = SRC[47-8*k -: 8];
        frm[12] = eth[15:8];
        frm[13] = eth[7:0];
        for (int k = 0; k < 20; k++) frm[14+k] = iph[159-8*k -: 8];
        frm[34] = sport[15:8];
        frm[35] = sport[7:0];
        frm[36] = 8'h12;
        frm[37] = 8'h34;
        frm[38] = 8'h00;
        frm[39] = 8'h5F;
        frm[40] = 8'h00;
        frm[41] = 8'h00;
    endtask

    task automatic pulse();
        @(negedge clk);
        pv  = 1'b1;
        msg = 8'h00;
    endtask

    task automatic drive(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            @(negedge clk);
            pv  = 1'b0;
            msg = frm[i];
        end
    endtask

    // DONE cycle: the cycle after byte 41 was sampled.
    task automatic verdict(input string tag, input bit mv, input bit nv, input bit next);
        @(negedge clk);
        pv  = next;
        msg = 8'h00;
        chk({tag, "_busy"}, 64'(m_busy), 64'(0));
        chk({tag, "_valid"}, 64'(m_valid), 64'(mv));
        chk({tag, "_error"}, 64'(m_err), 64'(!mv));
        chk({tag, "_nf_valid"}, 64'(n_valid), 64'(nv));
        chk({tag, "_nf_error"}, 64'(n_err), 64'(!nv));
    endtask

    task automatic chk_fields(input string tag, input logic [47:0] dst, input logic [15:0] sport);
        chk({tag, "_dst_mac"}, 64'(m_dst_mac), 64'(dst));
        chk({tag, "_src_mac"}, 64'(m_src_mac), 64'(SRC));
        chk({tag, "_ethertype"}, 64'(m_eth), 64'(16'h0800));
        chk({tag, "_src_ip"}, 64'(m_sip), 64'(32'hC0A8_0001));
        chk({tag, "_dst_ip"}, 64'(m_dip), 64'(32'hC0A8_00C7));
        chk({tag, "_src_port"}, 64'(m_sport), 64'(sport));
        chk({tag, "_dst_port"}, 64'(m_dport), 64'(16'h1234));
        chk({tag, "_udp_len"}, 64'(m_ulen), 64'(16'h005F));
    endtask

    initial begin
        // Reset and idle behaviour
        repeat (2) @(negedge clk);
        chk("rst_state", 64'(m_state), 64'(0));
        chk("rst_dst_mac", 64'(m_dst_mac), 64'(0));
        chk("rst_udp_len", 64'(m_ulen), 64'(0));
        chk("rst_busy", 64'(m_busy), 64'(0));
        chk("rst_valid", 64'(m_valid), 64'(0));
        chk("rst_error", 64'(m_err), 64'(0));
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            msg = 8'hA5;
        end
        @(negedge clk);
        chk("idle_busy", 64'(m_busy), 64'(0));
        chk("idle_state", 64'(m_state), 64'(0));

        // Good broadcast frame
        build(BCAST, 16'h0800, 16'hB861, 16'hABCD);
        pulse();
        drive(0, 20);
        chk("t1_busy_mid", 64'(m_busy), 64'(1));
        drive(21, 41);
        verdict("t1", 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        chk("t1_valid_after", 64'(m_valid), 64'(0));
        chk_fields("t1", BCAST, 16'hABCD);

        // Wrong ethertype: rejected, outputs keep previous header
        build(BCAST, 16'h86DD, 16'hB861, 16'h7777);
        pulse();
        drive(0, 41);
        verdict("t2", 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk_fields("t2", BCAST, 16'hABCD);

        // Foreign unicast dst: rejected only by the filtering instance
        build(OTHER, 16'h0800, 16'hB861, 16'h0101);
        pulse();
        drive(0, 41);
        verdict("t3", 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        chk("t3_dst_mac", 64'(m_dst_mac), 64'(BCAST));
        chk("t3_nf_dst_mac", 64'(n_dst_mac), 64'(OTHER));

        // Local MAC, with a new preamble in the DONE cycle
        build(LMAC, 16'h0800, 16'hB861, 16'h1111);
        pulse();
        drive(0, 41);
        verdict("t4a", 1'b1, 1'b1, 1'b1);
        build(LMAC, 16'h0800, 16'hB861, 16'h2222);
        drive(0, 41);
        verdict("t4b", 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        chk_fields("t4", LMAC, 16'h2222);

        // Restart at byte 20: first header gives no verdict
        build(BCAST, 16'h0800, 16'hB861, 16'h3333);
        pulse();
        drive(0, 19);
        #1;
        v0 = vcnt;
        e0 = ecnt;
        build(LMAC, 16'h0800, 16'hB861, 16'h4321);
        pulse();
        drive(0, 41);
        #1;
        chk("t5_no_valid", 64'(vcnt), 64'(v0));
        chk("t5_no_error", 64'(ecnt), 64'(e0));
        verdict("t5", 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        chk_fields("t5", LMAC, 16'h4321);

        // Reset at byte 30
        build(BCAST, 16'h0800, 16'hB861, 16'h5555);
        pulse();
        drive(0, 29);
        @(negedge clk);
        #1;
        v0 = vcnt;
        e0 = ecnt;
        rst_n = 1'b0;
        #1;
        chk("t6_dst_mac", 64'(m_dst_mac), 64'(0));
        chk("t6_src_ip", 64'(m_sip), 64'(0));
        chk("t6_dst_port", 64'(m_dport), 64'(0));
        chk("t6_ethertype", 64'(m_eth), 64'(0));
        chk("t6_busy", 64'(m_busy), 64'(0));
        chk("t6_state", 64'(m_state), 64'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("t6_no_valid", 64'(vcnt), 64'(v0));
        chk("t6_no_error", 64'(ecnt), 64'(e0));
        pulse();
        drive(0, 41);
        verdict("t6", 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        chk_fields("t6", BCAST, 16'h5555);

        // Corrupted IPv4 checksum
        build(BCAST, 16'h0800, 16'hB862, 16'h6666);
        pulse();
        drive(0, 41);
`ifdef IP_CSUM_CHECK_EN
        verdict("t7", 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk_fields("t7", BCAST, 16'h5555);
`else
        verdict("t7", 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        chk_fields("t7", BCAST, 16'h6666);
`endif

        #1;
        chk("never_both", 64'(both), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
